// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, fixed-latency RAM between instruction fetch and
// data load/store: one access in flight, data priority with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  input  logic [3:0]    dm_be,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_be,
  input  logic [31:0]   ram_rdata
);

  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            owner_if_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            killed_q;
  logic [WW-1:0]   wait_q;
  logic [SW-1:0]   starve_q;
  logic [31:0]     cap_q;
  logic [31:0]     if_rdata_q;
  logic [31:0]     dm_rdata_q;
  logic            fetch_win, dm_win;
  logic            issue, resp_if, resp_dm;

  always_comb begin
    state_d   = state_q;
    fetch_win = 1'b0;
    dm_win    = 1'b0;
    case (state_q)
      IDLE: begin
        fetch_win = if_req && (!dm_req || (starve_q == SW'(STARVE_LIMIT)));
        dm_win    = dm_req && !fetch_win;
        if (fetch_win || dm_win) state_d = ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants are combinational from the requests, so gate them explicitly while in reset.
  assign if_gnt  = fetch_win && rst;
  assign dm_gnt  = dm_win && rst;

  assign issue     = (state_q == ISSUE);
  assign ram_en    = issue;
  assign ram_we    = issue && we_q;
  assign ram_addr  = issue ? addr_q  : '0;
  assign ram_wdata = issue ? wdata_q : '0;
  assign ram_be    = issue ? be_q    : '0;

  assign resp_if   = (state_q == RESP) && owner_if_q && !killed_q;
  assign resp_dm   = (state_q == RESP) && !owner_if_q;
  assign if_rvalid = resp_if;
  assign dm_rvalid = resp_dm;
  assign if_rdata  = resp_if ? cap_q : if_rdata_q;
  assign dm_rdata  = (resp_dm && !we_q) ? cap_q : dm_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_if_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      killed_q   <= 1'b0;
      wait_q     <= '0;
      starve_q   <= '0;
      cap_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (fetch_win || dm_win) begin
            owner_if_q <= fetch_win;
            we_q       <= dm_win && dm_we;
            addr_q     <= fetch_win ? if_addr : dm_addr;
            wdata_q    <= fetch_win ? '0 : dm_wdata;
            be_q       <= fetch_win ? '1 : dm_be;
            killed_q   <= fetch_win && if_kill;
            if (fetch_win)
              starve_q <= '0;
            else if (if_req && (starve_q != SW'(STARVE_LIMIT)))
              starve_q <= starve_q + SW'(1);
          end
        end
        ISSUE: begin
          wait_q <= WW'(LATENCY - 1);
          if (owner_if_q && if_kill) killed_q <= 1'b1;
        end
        WAIT: begin
          if (owner_if_q && if_kill) killed_q <= 1'b1;
          if (wait_q == '0) cap_q  <= ram_rdata;
          else              wait_q <= wait_q - WW'(1);
        end
        RESP: begin
          if (resp_if)            if_rdata_q <= cap_q;
          if (resp_dm && !we_q)   dm_rdata_q <= cap_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic, checked every
// cycle against a transaction-level timing model and a small RAM model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int LIM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, ram_rdata;
  logic [3:0]  dm_be;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, ram_en, ram_we;
  logic [31:0] if_rdata, dm_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_be;

  mem_port_arbiter #(.AW(32), .LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0, fails = 0;

  // Reference model: one transaction record plus cycle arithmetic.
  int          cyc = 0, free_at = 0, starve = 0, t_gnt = 0, rd_at = -1;
  bit          act = 0, t_if = 0, t_we = 0, t_killed = 0, got_if = 0, got_dm = 0;
  logic [31:0] t_addr, t_wdata, t_data, rd_val, e_if_rdata, e_dm_rdata;
  logic [3:0]  t_be;
  logic [31:0] mem [16];

  logic        s_if_gnt, s_dm_gnt, s_ram_en, s_ram_we, s_if_rvalid, s_dm_rvalid;
  logic [31:0] s_ram_addr, s_ram_wdata, s_if_rdata, s_dm_rdata;
  logic [3:0]  s_ram_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit fw, dw, e_en, e_ir, e_dr;
    int idx;
    @(negedge clk);
    s_if_gnt = if_gnt; s_dm_gnt = dm_gnt; s_ram_en = ram_en; s_ram_we = ram_we;
    s_ram_addr = ram_addr; s_ram_wdata = ram_wdata; s_ram_be = ram_be;
    s_if_rvalid = if_rvalid; s_dm_rvalid = dm_rvalid; s_if_rdata = if_rdata; s_dm_rdata = dm_rdata;
    fw = 0; dw = 0;
    if (cyc >= free_at) begin
      fw = if_req && (!dm_req || starve == LIM);
      dw = dm_req && !fw;
    end
    if (fw || dw) begin
      act = 1; t_gnt = cyc; t_if = fw; t_we = dw && dm_we;
      t_addr = fw ? if_addr : dm_addr; t_wdata = dm_wdata; t_be = fw ? 4'hf : dm_be;
      t_killed = 0; free_at = cyc + 3 + LAT;
      if (fw) starve = 0;
      else if (if_req && starve < LIM) starve++;
    end
    if (act && t_if && if_kill && cyc <= t_gnt + 1 + LAT) t_killed = 1;
    e_en = act && cyc == t_gnt + 1;
    e_ir = act && t_if && !t_killed && cyc == t_gnt + 2 + LAT;
    e_dr = act && !t_if && cyc == t_gnt + 2 + LAT;
    if (e_ir) e_if_rdata = t_data;
    if (e_dr && !t_we) e_dm_rdata = t_data;
    chk("if_gnt", 32'(s_if_gnt), 32'(fw));
    chk("dm_gnt", 32'(s_dm_gnt), 32'(dw));
    chk("ram_en", 32'(s_ram_en), 32'(e_en));
    chk("ram_we", 32'(s_ram_we), 32'(e_en && t_we));
    chk("ram_addr", s_ram_addr, e_en ? t_addr : 32'h0);
    chk("ram_be", 32'(s_ram_be), e_en ? 32'(t_be) : 32'h0);
    if (!(e_en && t_if)) chk("ram_wdata", s_ram_wdata, e_en ? t_wdata : 32'h0);
    chk("if_rvalid", 32'(s_if_rvalid), 32'(e_ir));
    chk("dm_rvalid", 32'(s_dm_rvalid), 32'(e_dr));
    chk("if_rdata", s_if_rdata, e_if_rdata);
    chk("dm_rdata", s_dm_rdata, e_dm_rdata);
    if (e_en) begin
      idx = int'(t_addr[5:2]);
      t_data = mem[idx];
      if (t_we) begin
        for (int b = 0; b < 4; b++)
          if (t_be[b]) mem[idx][8*b +: 8] = t_wdata[8*b +: 8];
      end else begin
        rd_at = cyc + LAT; rd_val = mem[idx];
      end
    end
    if (act && cyc == t_gnt + 2 + LAT) act = 0;
    got_if = fw; got_dm = dw;
    @(posedge clk); #1;
    cyc++;
    ram_rdata = (cyc == rd_at) ? rd_val : $urandom;
  endtask

  task automatic do_reset();
    if_req = 1; dm_req = 1; rst = 0;
    #1;
    chk("rst_if_gnt", 32'(if_gnt), 32'h0);     chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'h0); chk("rst_dm_rvalid", 32'(dm_rvalid), 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);      chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);     chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);      chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_ram_be", 32'(ram_be), 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_gnt", 32'({if_gnt, dm_gnt}), 32'h0);
    rst = 1; if_req = 0; dm_req = 0;
    cyc++; act = 0; free_at = cyc; starve = 0; rd_at = -1;
    e_if_rdata = 0; e_dm_rdata = 0;
    ram_rdata = $urandom;
  endtask

  bit gq[$];
  bit exp_order [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    rst = 0; if_req = 0; if_kill = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0; ram_rdata = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    do_reset();

    // Single fetch
    mem[4] = 32'h00500293;
    if_req = 1; if_addr = 32'h10; tick();
    chk("t1_if_gnt", 32'(s_if_gnt), 32'h1);
    if_req = 0; tick();
    chk("t1_ram_en", 32'(s_ram_en), 32'h1); chk("t1_ram_addr", s_ram_addr, 32'h10);
    repeat (3) tick();
    chk("t1_if_rvalid", 32'(s_if_rvalid), 32'h1); chk("t1_if_rdata", s_if_rdata, 32'h00500293);
    repeat (2) tick();

    // Contention: data first, fetch right after
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h100; tick();
    chk("t2_dm_gnt", 32'(s_dm_gnt), 32'h1); chk("t2_if_gnt0", 32'(s_if_gnt), 32'h0);
    dm_req = 0; repeat (4) tick();
    chk("t2_dm_rvalid", 32'(s_dm_rvalid), 32'h1); chk("t2_dm_rdata", s_dm_rdata, mem[0]);
    tick();
    chk("t2_if_gnt", 32'(s_if_gnt), 32'h1);
    if_req = 0; repeat (4) tick();
    chk("t2_if_rvalid", 32'(s_if_rvalid), 32'h1);
    repeat (2) tick();

    // Starvation guard, both requests held
    for (int i = 0; i < 60 && gq.size() < 6; i++) begin
      if_req = 1; dm_req = 1; if_addr = 32'h4 * i; dm_addr = 32'h40 + 32'h4 * i;
      tick();
      if (s_dm_gnt) gq.push_back(0);
      if (s_if_gnt) gq.push_back(1);
    end
    if_req = 0; dm_req = 0;
    chk("t3_grant_count", 32'(gq.size()), 32'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++) chk("t3_grant_order", 32'(gq[i]), 32'(exp_order[i]));
    repeat (6) tick();

    // Store
    dm_req = 1; dm_we = 1; dm_addr = 32'h8; dm_be = 4'b0011; dm_wdata = 32'hDEADBEEF; tick();
    dm_req = 0; dm_we = 0; tick();
    chk("t4_ram_we", 32'(s_ram_we), 32'h1); chk("t4_ram_be", 32'(s_ram_be), 32'h3);
    chk("t4_ram_wdata", s_ram_wdata, 32'hDEADBEEF);
    repeat (3) tick();
    chk("t4_dm_rvalid", 32'(s_dm_rvalid), 32'h1); chk("t4_dm_rdata", s_dm_rdata, e_dm_rdata);
    repeat (2) tick();

    // Kill an in-flight fetch, then a fresh fetch
    if_req = 1; if_addr = 32'h4; tick();
    if_req = 0; tick();
    if_kill = 1; tick();
    if_kill = 0; repeat (2) tick();
    chk("t5_no_rvalid", 32'(s_if_rvalid), 32'h0);
    if_req = 1; if_addr = 32'hC; tick();
    chk("t5_if_gnt", 32'(s_if_gnt), 32'h1);
    if_req = 0; repeat (4) tick();
    chk("t5_if_rvalid", 32'(s_if_rvalid), 32'h1); chk("t5_if_rdata", s_if_rdata, mem[3]);
    repeat (2) tick();

    // Reset in the middle of a load
    dm_req = 1; dm_we = 0; dm_addr = 32'h14; tick();
    dm_req = 0; tick();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_rvalid", 32'(s_dm_rvalid), 32'h0);
    end
    dm_req = 1; dm_addr = 32'h18; tick();
    chk("t6_dm_gnt", 32'(s_dm_gnt), 32'h1);
    dm_req = 0; repeat (4) tick();
    chk("t6_dm_rvalid", 32'(s_dm_rvalid), 32'h1); chk("t6_dm_rdata", s_dm_rdata, mem[6]);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (!if_req) begin
        if ($urandom_range(0, 99) < 40) begin if_req = 1; if_addr = $urandom; end
      end else if ($urandom_range(0, 99) < 3) if_req = 0;
      if (!dm_req) begin
        if ($urandom_range(0, 99) < 40) begin
          dm_req = 1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom;
          dm_wdata = $urandom; dm_be = 4'($urandom);
        end
      end else if ($urandom_range(0, 99) < 3) dm_req = 0;
      if_kill = ($urandom_range(0, 99) < 8);
      tick();
      if (got_if) if_req = 0;
      if (got_dm) dm_req = 0;
    end
    if_req = 0; dm_req = 0; if_kill = 0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
